// File: rtl/lc3_console_mmio.sv
// LC-3 console controller: keyboard RX FIFO, display TX FIFO, KBSR/KBDR/DSR/DDR/MCR registers.
module lc3_console_mmio #(
    parameter int unsigned RX_DEPTH = 8,
    parameter int unsigned TX_DEPTH = 8,
    parameter int unsigned CHAR_W   = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [15:0]       addr,
    input  logic              mem_en,
    input  logic              r_w,
    input  logic [15:0]       din,
    output logic              sel,
    output logic [15:0]       dout,
    output logic              ready,
    input  logic              rx_valid,
    input  logic [CHAR_W-1:0] rx_data,
    output logic              rx_ready,
    output logic              tx_valid,
    output logic [CHAR_W-1:0] tx_data,
    input  logic              tx_ready,
    output logic              irq_kb,
    output logic              irq_disp,
    output logic              run
);

    localparam int unsigned RX_AW = (RX_DEPTH > 1) ? $clog2(RX_DEPTH) : 1;
    localparam int unsigned TX_AW = (TX_DEPTH > 1) ? $clog2(TX_DEPTH) : 1;
    localparam int unsigned RX_CW = $clog2(RX_DEPTH + 1);
    localparam int unsigned TX_CW = $clog2(TX_DEPTH + 1);

    localparam logic [15:0] A_KBSR = 16'hFE00;
    localparam logic [15:0] A_KBDR = 16'hFE02;
    localparam logic [15:0] A_DSR  = 16'hFE04;
    localparam logic [15:0] A_DDR  = 16'hFE06;
    localparam logic [15:0] A_MCR  = 16'hFFFE;

    logic [CHAR_W-1:0] r_rx_mem [RX_DEPTH];
    logic [CHAR_W-1:0] r_tx_mem [TX_DEPTH];
    logic [RX_AW-1:0]  r_rx_wr, r_rx_rd;
    logic [TX_AW-1:0]  r_tx_wr, r_tx_rd;
    logic [RX_CW-1:0]  r_rx_cnt;
    logic [TX_CW-1:0]  r_tx_cnt;
    logic              r_kb_ie, r_disp_ie, r_ovf;
    logic [15:0]       r_mcr;
    logic [15:0]       r_dout;
    logic              r_ready;

    logic w_acc, w_rd, w_wr;
    logic w_rx_nempty, w_tx_nfull;
    logic w_rx_push, w_rx_pop, w_tx_push, w_tx_pop, w_tx_drop;
    logic [15:0] w_rdata;

    // Address decode and access qualification
    assign sel   = (addr == A_KBSR) || (addr == A_KBDR) || (addr == A_DSR) ||
                   (addr == A_DDR)  || (addr == A_MCR);
    assign w_acc = mem_en & sel;
    assign w_rd  = w_acc & ~r_w;
    assign w_wr  = w_acc &  r_w;

    // FIFO status derived only from registered occupancy
    assign w_rx_nempty = (r_rx_cnt != '0);
    assign w_tx_nfull  = (r_tx_cnt != TX_CW'(TX_DEPTH));
    assign rx_ready    = (r_rx_cnt != RX_CW'(RX_DEPTH));
    assign tx_valid    = (r_tx_cnt != '0);
    assign tx_data     = r_tx_mem[r_tx_rd];

    assign w_rx_push = rx_valid & rx_ready;
    assign w_rx_pop  = w_rd & (addr == A_KBDR) & w_rx_nempty;
    assign w_tx_push = w_wr & (addr == A_DDR) & w_tx_nfull;
    assign w_tx_drop = w_wr & (addr == A_DDR) & ~w_tx_nfull;
    assign w_tx_pop  = tx_valid & tx_ready;

    assign irq_kb   = w_rx_nempty & r_kb_ie;
    assign irq_disp = w_tx_nfull & r_disp_ie;
    assign run      = r_mcr[15];
    assign dout     = r_dout;
    assign ready    = r_ready;

    // Read-data mux reflecting pre-edge state
    always_comb begin
        w_rdata = '0;
        if (addr == A_KBSR) begin
            w_rdata = {w_rx_nempty, r_kb_ie, 14'b0};
        end else if (addr == A_KBDR) begin
            if (w_rx_nempty) w_rdata = 16'(r_rx_mem[r_rx_rd]);
        end else if (addr == A_DSR) begin
            w_rdata = {w_tx_nfull, r_disp_ie, 13'b0, r_ovf};
        end else if (addr == A_MCR) begin
            w_rdata = r_mcr;
        end
    end

    // FIFO storage writes (contents are not reset; pointers define validity)
    always_ff @(posedge clk) begin
        if (reset && w_rx_push) r_rx_mem[r_rx_wr] <= rx_data;
        if (reset && w_tx_push) r_tx_mem[r_tx_wr] <= din[CHAR_W-1:0];
    end

    // RX FIFO pointers and occupancy
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_rx_wr  <= '0;
            r_rx_rd  <= '0;
            r_rx_cnt <= '0;
        end else begin
            if (w_rx_push) r_rx_wr <= r_rx_wr + RX_AW'(1);
            if (w_rx_pop)  r_rx_rd <= r_rx_rd + RX_AW'(1);
            if (w_rx_push && !w_rx_pop)      r_rx_cnt <= r_rx_cnt + RX_CW'(1);
            else if (!w_rx_push && w_rx_pop) r_rx_cnt <= r_rx_cnt - RX_CW'(1);
        end
    end

    // TX FIFO pointers and occupancy
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_tx_wr  <= '0;
            r_tx_rd  <= '0;
            r_tx_cnt <= '0;
        end else begin
            if (w_tx_push) r_tx_wr <= r_tx_wr + TX_AW'(1);
            if (w_tx_pop)  r_tx_rd <= r_tx_rd + TX_AW'(1);
            if (w_tx_push && !w_tx_pop)      r_tx_cnt <= r_tx_cnt + TX_CW'(1);
            else if (!w_tx_push && w_tx_pop) r_tx_cnt <= r_tx_cnt - TX_CW'(1);
        end
    end

    // Control registers: interrupt enables, overrun sticky bit, MCR
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_kb_ie   <= 1'b0;
            r_disp_ie <= 1'b0;
            r_ovf     <= 1'b0;
            r_mcr     <= 16'h8000;
        end else begin
            if (w_wr && addr == A_KBSR) r_kb_ie <= din[14];
            if (w_wr && addr == A_DSR) begin
                r_disp_ie <= din[14];
                if (din[0]) r_ovf <= 1'b0;
            end else if (w_tx_drop) begin
                r_ovf <= 1'b1;
            end
            if (w_wr && addr == A_MCR) r_mcr <= din;
        end
    end

    // Registered bus response: one-cycle ready, dout held between reads
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_ready <= 1'b0;
            r_dout  <= '0;
        end else begin
            r_ready <= w_acc;
            if (w_rd) r_dout <= w_rdata;
        end
    end

endmodule

// File: tb/tb_lc3_console_mmio.sv
// Directed bench for lc3_console_mmio with a read-data scoreboard and FIFO models.
module tb_lc3_console_mmio;

    localparam int unsigned RXD = 8;
    localparam int unsigned TXD = 8;
    localparam int unsigned CW  = 8;

    localparam logic [15:0] KBSR = 16'hFE00;
    localparam logic [15:0] KBDR = 16'hFE02;
    localparam logic [15:0] DSR  = 16'hFE04;
    localparam logic [15:0] DDR  = 16'hFE06;
    localparam logic [15:0] MCR  = 16'hFFFE;

    logic          clk = 1'b0;
    logic          reset;
    logic [15:0]   addr;
    logic          mem_en;
    logic          r_w;
    logic [15:0]   din;
    logic          sel;
    logic [15:0]   dout;
    logic          ready;
    logic          rx_valid;
    logic [CW-1:0] rx_data;
    logic          rx_ready;
    logic          tx_valid;
    logic [CW-1:0] tx_data;
    logic          tx_ready;
    logic          irq_kb;
    logic          irq_disp;
    logic          run;

    int tests = 0;
    int fails = 0;

    logic [15:0]   exp_q [$];
    logic [CW-1:0] rx_m  [$];
    logic [CW-1:0] tx_m  [$];

    lc3_console_mmio #(.RX_DEPTH(RXD), .TX_DEPTH(TXD), .CHAR_W(CW)) dut (
        .clk(clk), .reset(reset), .addr(addr), .mem_en(mem_en), .r_w(r_w),
        .din(din), .sel(sel), .dout(dout), .ready(ready),
        .rx_valid(rx_valid), .rx_data(rx_data), .rx_ready(rx_ready),
        .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(tx_ready),
        .irq_kb(irq_kb), .irq_disp(irq_disp), .run(run)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One bus access; reads pop their expected data from the scoreboard
    task automatic access(input logic [15:0] a, input logic w, input logic [15:0] d, input string tag);
        logic [15:0] e;
        @(negedge clk);
        addr = a; r_w = w; din = d; mem_en = 1'b1;
        @(posedge clk); #1;
        mem_en = 1'b0;
        check({tag, "_ready"}, 32'(ready), 32'd1);
        if (!w) begin
            e = exp_q.pop_front();
            check(tag, 32'(dout), 32'(e));
        end
    endtask

    task automatic rd(input logic [15:0] a, input logic [15:0] e, input string tag);
        exp_q.push_back(e);
        access(a, 1'b0, 16'h0, tag);
    endtask

    task automatic wr(input logic [15:0] a, input logic [15:0] d, input string tag);
        access(a, 1'b1, d, tag);
    endtask

    // KBDR read whose expectation comes from the RX model
    task automatic rd_kbdr(input string tag);
        logic [15:0] e;
        e = (rx_m.size() > 0) ? 16'(rx_m.pop_front()) : 16'h0000;
        rd(KBDR, e, tag);
    endtask

    task automatic push_rx(input logic [CW-1:0] c);
        @(negedge clk);
        rx_valid = 1'b1; rx_data = c;
        @(posedge clk); #1;
        rx_valid = 1'b0;
        if (rx_m.size() < RXD) rx_m.push_back(c);
    endtask

    task automatic wr_ddr(input logic [CW-1:0] c, input string tag);
        wr(DDR, 16'(c), tag);
        if (tx_m.size() < TXD) tx_m.push_back(c);
    endtask

    initial begin
        reset = 1'b0; addr = 16'h0; mem_en = 1'b0; r_w = 1'b0; din = 16'h0;
        rx_valid = 1'b0; rx_data = '0; tx_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_ready", 32'(ready), 32'd0);
        check("rst_dout", 32'(dout), 32'h0);
        check("rst_rx_ready", 32'(rx_ready), 32'd1);
        check("rst_tx_valid", 32'(tx_valid), 32'd0);
        check("rst_run", 32'(run), 32'd1);
        @(negedge clk); reset = 1'b1;

        rd(KBSR, 16'h0000, "post_kbsr");
        rd(DSR,  16'h8000, "post_dsr");
        rd(MCR,  16'h8000, "post_mcr");

        // Unclaimed address: no sel, no ready
        @(negedge clk); addr = 16'h3000; r_w = 1'b0; mem_en = 1'b1; #1;
        check("sel_off", 32'(sel), 32'd0);
        @(posedge clk); #1; mem_en = 1'b0;
        check("nosel_ready", 32'(ready), 32'd0);
        addr = MCR; #1;
        check("sel_mcr", 32'(sel), 32'd1);

        // Basic keyboard path
        push_rx(8'h48);
        push_rx(8'h69);
        rd(KBSR, 16'h8000, "kbsr_ne");
        rd_kbdr("kbdr_H");
        rd_kbdr("kbdr_i");
        rd(KBSR, 16'h0000, "kbsr_empty");
        rd_kbdr("kbdr_empty");

        // Fill RX FIFO, pop one, refill across the pointer wrap
        for (int i = 0; i < RXD; i++) push_rx(CW'(8'h10 + i));
        check("rx_full", 32'(rx_ready), 32'd0);
        rd_kbdr("kbdr_full0");
        check("rx_ready_back", 32'(rx_ready), 32'd1);
        push_rx(CW'(8'h10 + RXD));
        for (int i = 0; i < RXD; i++) rd_kbdr("kbdr_wrap");
        rd(KBSR, 16'h0000, "kbsr_drained");

        // TX overrun with display stalled
        for (int i = 0; i <= TXD; i++) wr_ddr(CW'(8'h41 + i), "ddr_fill");
        rd(DSR, 16'h0001, "dsr_ovf");
        check("tx_head", 32'(tx_data), 32'h41);
        wr(DSR, 16'h0001, "dsr_clr");
        rd(DSR, 16'h0000, "dsr_cleared");
        @(negedge clk); tx_ready = 1'b1;
        for (int n = 0; n < 2 * TXD && tx_m.size() > 0; n++) begin
            check("tx_valid_drain", 32'(tx_valid), 32'd1);
            check("tx_data_drain", 32'(tx_data), 32'(tx_m.pop_front()));
            @(negedge clk);
        end
        check("tx_drain_done", 32'(tx_m.size()), 32'd0);
        tx_ready = 1'b0;
        check("tx_empty", 32'(tx_valid), 32'd0);
        rd(DSR, 16'h8000, "dsr_notfull");

        // Interrupts
        wr(KBSR, 16'h4000, "kb_ie");
        check("irq_kb_idle", 32'(irq_kb), 32'd0);
        push_rx(8'h5A);
        check("irq_kb_set", 32'(irq_kb), 32'd1);
        rd(KBSR, 16'hC000, "kbsr_ie_ne");
        rd_kbdr("kbdr_irq");
        check("irq_kb_clr", 32'(irq_kb), 32'd0);
        check("irq_disp_off", 32'(irq_disp), 32'd0);
        wr(DSR, 16'h4000, "disp_ie");
        check("irq_disp_on", 32'(irq_disp), 32'd1);

        // Full TX: DDR write and drain on the same edge still overruns
        for (int i = 0; i < TXD; i++) wr_ddr(CW'(8'h61 + i), "ddr_fill2");
        check("irq_disp_full", 32'(irq_disp), 32'd0);
        @(negedge clk);
        addr = DDR; r_w = 1'b1; din = 16'h007A; mem_en = 1'b1; tx_ready = 1'b1;
        @(posedge clk); #1;
        mem_en = 1'b0; tx_ready = 1'b0;
        void'(tx_m.pop_front());
        check("same_edge_ready", 32'(ready), 32'd1);
        rd(DSR, 16'hC001, "dsr_same_edge");
        check("tx_head2", 32'(tx_data), 32'(tx_m[0]));

        // Machine control register
        wr(MCR, 16'h0000, "mcr_clr");
        check("run_off", 32'(run), 32'd0);
        wr(MCR, 16'h1234, "mcr_store");
        rd(MCR, 16'h1234, "mcr_rd");

        // Reset during an access with both FIFOs part-full
        push_rx(8'h31); push_rx(8'h32); push_rx(8'h33);
        @(negedge clk);
        reset = 1'b0; addr = KBDR; r_w = 1'b0; mem_en = 1'b1;
        @(posedge clk); #1;
        mem_en = 1'b0;
        rx_m.delete(); tx_m.delete();
        check("mid_rst_ready", 32'(ready), 32'd0);
        check("mid_rst_dout", 32'(dout), 32'h0);
        check("mid_rst_rx_ready", 32'(rx_ready), 32'd1);
        check("mid_rst_tx_valid", 32'(tx_valid), 32'd0);
        check("mid_rst_run", 32'(run), 32'd1);
        check("mid_rst_irq_kb", 32'(irq_kb), 32'd0);
        @(negedge clk); reset = 1'b1;
        rd(KBSR, 16'h0000, "rst2_kbsr");
        rd(DSR,  16'h8000, "rst2_dsr");
        rd(MCR,  16'h8000, "rst2_mcr");
        rd_kbdr("rst2_kbdr");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/lc3_console_mmio.md
# lc3_console_mmio

Synthesizable memory-mapped console controller for the LC-3 datapath. It replaces behavioural poking of the KBSR/KBDR/DSR/DDR/MCR registers with real hardware: a parametrised receive FIFO for keyboard characters, a transmit FIFO for display characters, interrupt-enable bits and a machine-control register. It sits on the memory bus beside main memory, claims the device-register page and hands characters to and from external character-stream endpoints.

## Interface
- RX_DEPTH, 8: keyboard FIFO entries (power of two, >=2)
- TX_DEPTH, 8: display FIFO entries (power of two, >=2)
- CHAR_W, 8: character width (1..16); register reads zero-extend to 16 bits
- clk  in  1  system clock; all state updates on rising edge
- reset  in  1  synchronous, active-low reset
- addr  in  16  bus address
- mem_en  in  1  bus access request, one cycle per access
- r_w  in  1  1 = write, 0 = read
- din  in  16  write data
- sel  out  1  combinational: addr is xFE00, xFE02, xFE04, xFE06 or xFFFE
- dout  out  16  registered read data
- ready  out  1  registered one-cycle access-complete pulse
- rx_valid  in  1  keyboard character offered
- rx_data  in  CHAR_W  keyboard character
- rx_ready  out  1  RX FIFO not full
- tx_valid  out  1  TX FIFO not empty
- tx_data  out  CHAR_W  TX FIFO head
- tx_ready  in  1  display accepts character
- irq_kb  out  1  keyboard interrupt request
- irq_disp  out  1  display interrupt request
- run  out  1  MCR[15]

## Operation
- Register map (unlisted bits read 0, writes ignored):
  - KBSR xFE00: [15] RX non-empty (RO), [14] KB IE (RW)
  - KBDR xFE02: read returns RX head zero-extended and pops it; read when empty returns x0000, no pop; writes ignored
  - DSR xFE04: [15] TX not full (RO), [14] display IE (RW), [0] TX overrun sticky (write 1 clears)
  - DDR xFE06: write pushes din[CHAR_W-1:0]; when full, character dropped and DSR[0] set; read returns x0000
  - MCR xFFFE: [15] run (RW); other bits RW storage
- RX push when rx_valid & rx_ready; TX pop when tx_valid & tx_ready.
- irq_kb = KBSR[15] & KBSR[14]; irq_disp = DSR[15] & DSR[14]; both combinational from registered state.
- Accesses with sel = 0 produce no ready pulse and no state change.
- FIFOs: circular buffers, pointers wrap modulo depth, occupancy counter 0..DEPTH.

## Timing
- Reset (reset = 0 at a rising edge): both FIFOs empty, IE bits 0, DSR[0] 0, MCR = x8000, dout x0000, ready 0. Post-reset reads: KBSR x0000, DSR x8000, MCR x8000. Reset overrides any access in the same cycle; FIFO contents discarded.
- Access: mem_en & sel sampled at edge N; register update/push/pop at edge N; dout and ready valid after edge N, for one cycle. dout holds its last value when ready = 0.
- Read data reflects state before edge N (KBDR returns head popped at edge N).
- Back-to-back accesses each cycle supported; each gets its own ready pulse.
- rx_ready and tx_valid derive from registered occupancy only (no same-cycle pass-through).
- Simultaneous push and pop on one FIFO: both happen, occupancy unchanged. Full TX FIFO with DDR write and tx_ready pop same edge: write dropped and DSR[0] set (full evaluated pre-edge).
- Write to DSR with din[0] = 1 and an overflowing DDR write cannot coincide (one access per cycle); an overrun caused earlier stays set until cleared.
- Write to MCR clearing bit 15 drops run after that edge; block keeps operating (run is an output only).

## Test plan
- Reset then read KBSR, DSR, MCR -> dout x0000, x8000, x8000, each with ready one cycle after mem_en.
- Push 'H'(x48),'i'(x69) via rx handshake; read KBSR -> x8000; read KBDR twice -> x0048, x0069; read KBSR -> x0000; KBDR on empty -> x0000.
- Push RX_DEPTH chars -> rx_ready = 0 after last; read KBDR once -> rx_ready = 1 next cycle; order preserved across pointer wrap.
- tx_ready = 0, write DDR TX_DEPTH+1 times -> DSR = x0001 (not full = 0, overrun = 1); extra char absent at tx_data; write DSR x0001 -> DSR reads x0000; release tx_ready -> chars drain in order, DSR[15] returns 1.
- Write KBSR x4000, push one char -> irq_kb = 1 cycle after push; pop it -> irq_kb = 0; write DSR x4000 with empty TX -> irq_disp = 1.
- Write MCR x0000 -> run = 0 next cycle; assert reset mid-burst with FIFOs part-full -> all FIFOs empty, run = 1, ready = 0.
